lockin_period_integrator: RTL

- Sits directly downstream of the synchro chopper stage.
- Accumulates the gated 14-bit sample stream over an integer number of whole chopper periods, aligned to chopper rising edges.
- Emits the window sum and sample count with a one-cycle valid strobe to the lock-in output/readout stage.
- Provides the low-pass/averaging function of the lock-in chain; division by the count is done downstream.

---
 rtl/lockin_pkg.sv | 26 ++
 rtl/chopper_edge_detect.sv | 29 ++
 rtl/lockin_period_integrator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lockin_pkg.sv
// lockin_pkg
//   Shared definitions for the lock-in amplifier chain.
//   - ST_IDLE / ST_ACCUM : integrator state encoding
//   - LOCKIN_DATA_W      : default sample width of the chopped stream
//   - lockin_clog2()     : ceil(log2(x)) for elaboration-time width checks
package lockin_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   localparam int LOCKIN_DATA_W = 14;

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int lockin_clog2(input longint unsigned value);
      int r;
      longint unsigned v;
      r = 0;
      v = 1;
      while (v < value) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/chopper_edge_detect.sv
// chopper_edge_detect
//   Registers the chopper reference once and flags its rising edge.
//   Ports:
//     clk  in   system clock (chopper is synchronous to it)
//     rst  in   synchronous active-high reset; clears the delay register
//     sig  in   chopper reference
//     rise out  sig & ~sig_delayed (combinational, same cycle as the edge)
//   Because the delay register resets to 0, a reference that is already high
//   in the first cycle after reset is reported as a rise.
module chopper_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic chop_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         chop_d <= 1'b0;
      end else begin
         chop_d <= sig;
      end
   end

   assign rise = sig & ~chop_d;

endmodule

// File: rtl/lockin_period_integrator.sv
// lockin_period_integrator
//   Integrates the gated sample stream over N_PERIODS whole chopper periods,
//   windows aligned to chopper rising edges, and hands the sum plus sample
//   count to the readout stage. Division by the count happens downstream.
//
//   Ports:
//     clk_in       in   system clock
//     rst_in       in   synchronous active-high reset
//     enable_in    in   integration enable; dropping it discards the window
//     chopper_sig  in   chopper reference
//     in_sig       in   signed DATA_W sample
//     acc_out      out  signed window sum, held between strobes
//     cnt_out      out  samples contained in acc_out
//     valid_out    out  one-cycle strobe when acc_out/cnt_out update
//     timeout_out  out  sticky: a window hit MAX_SAMPLES (chopper stalled)
//
//   Output protocol: valid_out is a push-only strobe with no back-pressure.
//   It is high for exactly one cycle, the cycle after the closing chopper
//   rise, and acc_out/cnt_out carry the new window in that same cycle and
//   hold it until the next strobe or reset.
//
//   Build option: define LOCKIN_BIPOLAR_EN for +/-1 demodulation (sample
//   added while chopper_sig=1, subtracted while 0). Without it every sample
//   is added, as the incoming stream is already gated.
module lockin_period_integrator
   import lockin_pkg::*;
#(
   parameter int DATA_W      = LOCKIN_DATA_W,
   parameter int N_PERIODS   = 16,
   parameter int MAX_SAMPLES = 65536,
   parameter int CNT_W       = 17,
   parameter int ACC_W       = 31
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              enable_in,
   input  logic              chopper_sig,
   input  logic [DATA_W-1:0] in_sig,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  cnt_out,
   output logic              valid_out,
   output logic              timeout_out
);

   localparam int PER_W = (N_PERIODS > 1) ? lockin_clog2(N_PERIODS) : 1;
   localparam logic [PER_W-1:0] LAST_PERIOD = PER_W'(N_PERIODS - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(MAX_SAMPLES);

   // The accumulator is sized so it can never wrap: MAX_SAMPLES full-scale
   // samples always fit. Refuse to elaborate a configuration that breaks this.
   if ((N_PERIODS < 1) ||
       (CNT_W < lockin_clog2(longint'(MAX_SAMPLES) + 1)) ||
       (ACC_W < DATA_W + CNT_W)) begin : g_param_check
      $error("lockin_period_integrator: invalid N_PERIODS/CNT_W/ACC_W");
   end

   logic             rise;
   logic [0:0]       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] sample_cnt;
   logic [PER_W-1:0] per_cnt;
   logic [ACC_W-1:0] sample_ext;
   logic [ACC_W-1:0] sample_term;

   chopper_edge_detect u_edge (
      .clk  (clk_in),
      .rst  (rst_in),
      .sig  (chopper_sig),
      .rise (rise)
   );

   assign sample_ext = {{(ACC_W - DATA_W){in_sig[DATA_W-1]}}, in_sig};

`ifdef LOCKIN_BIPOLAR_EN
   assign sample_term = chopper_sig ? sample_ext : (ACC_W'(0) - sample_ext);
`else
   assign sample_term = sample_ext;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= ST_IDLE;
         acc         <= '0;
         sample_cnt  <= '0;
         per_cnt     <= '0;
         acc_out     <= '0;
         cnt_out     <= '0;
         valid_out   <= 1'b0;
         timeout_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (state == ST_IDLE) begin
            // A window always opens on a rise, where chopper_sig=1, so the
            // opening sample is added in either demodulation mode.
            if (enable_in && rise) begin
               state      <= ST_ACCUM;
               acc        <= sample_ext;
               sample_cnt <= CNT_W'(1);
               per_cnt    <= '0;
            end
         end else begin
            if (!enable_in) begin
               state <= ST_IDLE;
            end else if (rise && (per_cnt == LAST_PERIOD)) begin
               // Publish the finished window and open the next one in the
               // same cycle: the edge-cycle sample belongs to the new window.
               acc_out    <= acc;
               cnt_out    <= sample_cnt;
               valid_out  <= 1'b1;
               acc        <= sample_ext;
               sample_cnt <= CNT_W'(1);
               per_cnt    <= '0;
            end else if (rise) begin
               per_cnt    <= per_cnt + PER_W'(1);
               acc        <= acc + sample_term;
               sample_cnt <= sample_cnt + CNT_W'(1);
            end else if (sample_cnt >= CNT_LIMIT) begin
               // Chopper stalled: abandon the window without a strobe.
               timeout_out <= 1'b1;
               state       <= ST_IDLE;
            end else begin
               acc        <= acc + sample_term;
               sample_cnt <= sample_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
